// File: rtl/ext_mem_responder.sv
// rtl/ext_mem_responder.sv - main-memory responder for a cache line-fill / write-back port
// Serves one line request at a time: fixed-latency read bursts, collected write-backs.
module ext_mem_responder #(
  parameter int BW_DATA_WORD   = 32,
  parameter int BW_ADDR_WORD   = 10,
  parameter int BW_WORDS       = 2,
  parameter int WORDS_PER_LINE = 4,
  parameter int LATENCY        = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    mem_request_i,
  input  logic                    mem_wren_i,
  input  logic [BW_ADDR_WORD-1:0] mem_addr_i,
  input  logic [BW_DATA_WORD-1:0] mem_data_i,
  input  logic                    mem_data_valid_i,
  output logic                    mem_ready_o,
  output logic                    mem_valid_o,
  output logic                    mem_last_o,
  output logic [BW_DATA_WORD-1:0] mem_data_o,
  output logic                    mem_done_o
);

  localparam int DEPTH   = 2 ** BW_ADDR_WORD;
  localparam int BW_LINE = BW_ADDR_WORD - BW_WORDS;
  localparam logic [BW_WORDS-1:0] LAST_WORD = BW_WORDS'(WORDS_PER_LINE - 1);
  localparam logic [7:0]          LAT_INIT  = 8'(LATENCY - 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_COLLECT, WR_WAIT} state_t;

  state_t                  state, state_n;
  logic [7:0]              lat_cnt, lat_cnt_n;
  logic [BW_WORDS-1:0]     word_cnt, word_cnt_n;
  logic [BW_LINE-1:0]      line_q, line_n;
  logic                    ready_n, valid_n, last_n, done_n;
  logic                    load_data, wr_en;
  logic [BW_ADDR_WORD-1:0] word_addr;
  logic [BW_DATA_WORD-1:0] rd_word;
  logic                    unused_addr_bits;

  // Words are stored XORed with their address, so zeroed power-up storage reads back as word i = i.
  logic [BW_DATA_WORD-1:0] mem [DEPTH];

  assign unused_addr_bits = ^mem_addr_i[BW_WORDS-1:0];
  assign word_addr        = {line_q, word_cnt};
  assign rd_word          = mem[word_addr] ^ BW_DATA_WORD'(word_addr);

  always_comb begin
    state_n    = state;
    lat_cnt_n  = lat_cnt;
    word_cnt_n = word_cnt;
    line_n     = line_q;
    ready_n    = 1'b0;
    valid_n    = 1'b0;
    last_n     = 1'b0;
    done_n     = 1'b0;
    load_data  = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (mem_ready_o && mem_request_i) begin
          ready_n    = 1'b0;
          line_n     = mem_addr_i[BW_ADDR_WORD-1:BW_WORDS];
          word_cnt_n = '0;
          if (mem_wren_i) begin
            state_n = WR_COLLECT;
          end else begin
            state_n   = RD_WAIT;
            lat_cnt_n = LAT_INIT;
          end
        end
      end
      RD_WAIT, RD_BURST: begin
        if (state == RD_WAIT && lat_cnt != 8'd0) begin
          lat_cnt_n = lat_cnt - 8'd1;
        end else if (state == RD_BURST && mem_last_o) begin
          state_n = IDLE;
          ready_n = 1'b1;
        end else begin
          // Word 0 leaves on the same edge the latency expires.
          state_n    = RD_BURST;
          valid_n    = 1'b1;
          last_n     = (word_cnt == LAST_WORD);
          load_data  = 1'b1;
          word_cnt_n = word_cnt + 1'b1;
        end
      end
      WR_COLLECT: begin
        if (mem_data_valid_i) begin
          wr_en      = 1'b1;
          word_cnt_n = word_cnt + 1'b1;
          if (word_cnt == LAST_WORD) begin
            state_n   = WR_WAIT;
            lat_cnt_n = LAT_INIT;
          end
        end
      end
      WR_WAIT: begin
        if (lat_cnt == 8'd0) begin
          state_n = IDLE;
          done_n  = 1'b1;
          ready_n = 1'b1;
        end else begin
          lat_cnt_n = lat_cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= IDLE;
      lat_cnt     <= 8'd0;
      word_cnt    <= '0;
      line_q      <= '0;
      mem_ready_o <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_last_o  <= 1'b0;
      mem_done_o  <= 1'b0;
      mem_data_o  <= '0;
    end else begin
      state       <= state_n;
      lat_cnt     <= lat_cnt_n;
      word_cnt    <= word_cnt_n;
      line_q      <= line_n;
      mem_ready_o <= ready_n;
      mem_valid_o <= valid_n;
      mem_last_o  <= last_n;
      mem_done_o  <= done_n;
      if (load_data) mem_data_o <= rd_word;
    end
  end

  always_ff @(posedge clock_i) begin
    if (wr_en && !reset_i) mem[word_addr] <= mem_data_i ^ BW_DATA_WORD'(word_addr);
  end

endmodule
